// File: rtl/conv_encoder.sv
// conv_encoder
//   Rate-1/2, constraint-length-4 (8-state) convolutional encoder. Takes one
//   information bit per handshake and emits one 2-bit coded symbol per
//   handshake through a single-entry output register.
//
//   Optional feature macro: CONV_ENC_TAIL_EN
//     defined   : every FRAME_LEN-bit frame is terminated with three zero tail
//                 bits so the trellis ends in state 0; sym_last marks the third
//                 tail symbol.
//     undefined : continuous encoding across frames, no tail; sym_last marks
//                 the FRAME_LEN-th data symbol of each frame.
//
// Parameters
//   FRAME_LEN  information bits per frame (1..1024)
//   G0         generator for sym[1]; bit 3 taps the current input bit
//   G1         generator for sym[0]; bit 3 taps the current input bit
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   enable     low = synchronous clear of all state
//   din        information bit
//   din_valid  din is valid
//   din_ready  encoder accepts din this cycle
//   sym        coded symbol {c1,c0}
//   sym_valid  sym is valid
//   sym_ready  downstream accepts sym this cycle
//   sym_last   qualifies the final symbol of a frame
module conv_encoder #(
  parameter int         FRAME_LEN = 64,
  parameter logic [3:0] G0        = 4'b1111,
  parameter logic [3:0] G1        = 4'b1101
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [1:0] sym,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic       sym_last
);

  localparam int            CW       = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_LEN - 1);

  logic [2:0]    s;
  logic [2:0]    s_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [1:0]    sym_next;
  logic          sym_valid_next;
  logic          sym_last_next;

  logic          in_data;
  logic          slot_free;
  logic          push;
  logic          u;
  logic [3:0]    r;
  logic [1:0]    code;

`ifdef CONV_ENC_TAIL_EN
  typedef enum logic {DATA, TAIL} state_t;

  state_t     state;
  state_t     state_next;
  logic [1:0] tail_cnt;
  logic [1:0] tail_cnt_next;

  assign in_data = (state == DATA);
`else
  assign in_data = 1'b1;
`endif

  // The output slot can take a new symbol when it is empty or being drained
  // in this same cycle, which is what sustains one symbol per cycle.
  assign slot_free = !sym_valid || sym_ready;

  // Gated by rst directly so the encoder never advertises readiness while it
  // is held in reset.
  assign din_ready = rst && enable && in_data && slot_free;

  // Tail cycles shift in zeros without consuming input.
  assign u    = in_data ? din : 1'b0;
  assign push = in_data ? (din_valid && din_ready) : (enable && slot_free);

  assign r    = {u, s};
  assign code = {^(r & G0), ^(r & G1)};

  // Next-state logic: everything holds by default, so a stalled output slot
  // freezes the shift register, the frame counter and the control state.
  always_comb begin
    s_next         = s;
    cnt_next       = cnt;
    sym_next       = sym;
    sym_valid_next = sym_valid;
    sym_last_next  = sym_last;
`ifdef CONV_ENC_TAIL_EN
    state_next     = state;
    tail_cnt_next  = tail_cnt;
`endif

    if (!enable) begin
      s_next         = '0;
      cnt_next       = '0;
      sym_next       = '0;
      sym_valid_next = 1'b0;
      sym_last_next  = 1'b0;
`ifdef CONV_ENC_TAIL_EN
      state_next     = DATA;
      tail_cnt_next  = '0;
`endif
    end else begin
      if (sym_valid && sym_ready) begin
        sym_valid_next = 1'b0;
        sym_last_next  = 1'b0;
      end

      if (push) begin
        sym_next       = code;
        sym_valid_next = 1'b1;
        sym_last_next  = 1'b0;
        s_next         = {u, s[2:1]};
`ifdef CONV_ENC_TAIL_EN
        if (state == DATA) begin
          if (cnt == LAST_BIT) begin
            state_next = TAIL;
            cnt_next   = '0;
          end else begin
            cnt_next   = cnt + CW'(1);
          end
        end else begin
          // A separate tail counter keeps cnt at its minimal width even when
          // FRAME_LEN is too small to count three tail symbols.
          if (tail_cnt == 2'd2) begin
            state_next    = DATA;
            tail_cnt_next = '0;
            sym_last_next = 1'b1;
          end else begin
            tail_cnt_next = tail_cnt + 2'd1;
          end
        end
`else
        sym_last_next = (cnt == LAST_BIT);
        cnt_next      = (cnt == LAST_BIT) ? '0 : cnt + CW'(1);
`endif
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s         <= '0;
      cnt       <= '0;
      sym       <= '0;
      sym_valid <= 1'b0;
      sym_last  <= 1'b0;
`ifdef CONV_ENC_TAIL_EN
      state     <= DATA;
      tail_cnt  <= '0;
`endif
    end else begin
      s         <= s_next;
      cnt       <= cnt_next;
      sym       <= sym_next;
      sym_valid <= sym_valid_next;
      sym_last  <= sym_last_next;
`ifdef CONV_ENC_TAIL_EN
      state     <= state_next;
      tail_cnt  <= tail_cnt_next;
`endif
    end
  end

endmodule
